seq_control_unit: RTL and testbench

SEQ_CONTROL_UNIT -- requirements
Module: seq_control_unit

---
 rtl/seq_control_unit_if.sv | 35 +++
 rtl/seq_control_unit.sv | 190 +++++++++++++++++++
 tb/tb_seq_control_unit.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_control_unit_if.sv
// Bus bundle between seq_control_unit and its instruction ROM, data RAM and ALU.
// master: the control unit side. slave: the memory/ALU side.
interface seq_control_unit_if #(
    parameter int DATA_W   = 16,
    parameter int ROM_SIZE = 16,
    parameter int RAM_SIZE = 16
);
    logic [ROM_SIZE-1:0] rom_address;
    logic [15:0]         instr;
    logic [RAM_SIZE-1:0] ram_address;
    logic                we;
    logic [DATA_W-1:0]   ram_in;
    logic [DATA_W-1:0]   ram_out;
    logic                alu_bgn;
    logic [5:0]          alu_op;
    logic [DATA_W-1:0]   alu_a;
    logic [DATA_W-1:0]   alu_b;
    logic [DATA_W-1:0]   alu_res;
    logic [3:0]          alu_flags;
    logic                alu_rdy;
    logic                halted;
    logic                err;

    modport master (
        output rom_address, ram_address, we, ram_out,
        output alu_bgn, alu_op, alu_a, alu_b, halted, err,
        input  instr, ram_in, alu_res, alu_flags, alu_rdy
    );

    modport slave (
        input  rom_address, ram_address, we, ram_out,
        input  alu_bgn, alu_op, alu_a, alu_b, halted, err,
        output instr, ram_in, alu_res, alu_flags, alu_rdy
    );
endinterface

// File: rtl/seq_control_unit.sv
// seq_control_unit: multi-cycle sequencer for a 4-register accumulator core.
// Every instruction takes FETCH + DECODE; loads/pops add a MEM cycle and ALU
// operations wait in WAIT for alu_rdy. ROM and RAM reads have one cycle latency.
// Optional feature: define CU_ALU_TIMEOUT_EN to abandon an ALU operation after
// TIMEOUT WAIT cycles and raise the sticky err flag.
module seq_control_unit #(
    parameter int DATA_W   = 16,
    parameter int ROM_SIZE = 16,
    parameter int RAM_SIZE = 16,
    parameter int TIMEOUT  = 64
) (
    input  logic              clk,
    input  logic              rst,
    seq_control_unit_if.master bus
);
    typedef enum logic [2:0] {FETCH, DECODE, MEM, WAIT, HALT} state_t;

    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_SHL  = 6'd3;
    localparam logic [5:0] OP_SHR  = 6'd4;
    localparam logic [5:0] OP_BRZ  = 6'd5;
    localparam logic [5:0] OP_BRN  = 6'd6;
    localparam logic [5:0] OP_JMP  = 6'd7;
    localparam logic [5:0] OP_LDR  = 6'd8;
    localparam logic [5:0] OP_STR  = 6'd9;
    localparam logic [5:0] OP_MOVI = 6'd10;
    localparam logic [5:0] OP_PUSH = 6'd11;
    localparam logic [5:0] OP_POP  = 6'd12;
    localparam logic [5:0] OP_HLT  = 6'd13;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   regs [4];
    logic [3:0]          flags;          // {Z,N,C,V}
    logic [ROM_SIZE-1:0] pc;
    logic [RAM_SIZE-1:0] sp;
    logic [15:0]         ir;             // instruction held for MEM/WAIT
    logic [15:0]         cur;
    logic [5:0]          op;
    logic [1:0]          rsel, bsel;
    logic [7:0]          imm;
    logic [ROM_SIZE-1:0] target, pc_inc;
    logic [RAM_SIZE-1:0] sp_inc, sp_dec;
    logic                is_alu;
    logic                timeout_hit;
    logic                unused_ok;

    // ROM data is only valid in DECODE; later cycles work from the latched copy
    assign cur    = (state == DECODE) ? bus.instr : ir;
    assign op     = cur[15:10];
    assign rsel   = cur[9:8];
    assign imm    = cur[7:0];
    assign bsel   = cur[1:0];
    assign target = ROM_SIZE'(cur[9:0]);
    assign pc_inc = pc + ROM_SIZE'(1);
    assign sp_inc = sp + RAM_SIZE'(1);
    assign sp_dec = sp - RAM_SIZE'(1);
    assign is_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_SHL) || (op == OP_SHR);

    // Operands come from the register file, which cannot change during WAIT,
    // so they stay stable until the ALU answers.
    assign bus.rom_address = pc;
    assign bus.alu_op      = op;
    assign bus.alu_a       = regs[rsel];
    assign bus.alu_b       = regs[bsel];
    assign bus.halted      = (state == HALT);

`ifdef CU_ALU_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;
    logic          err_q;

    // alu_rdy in the expiry cycle takes precedence over the timeout
    assign timeout_hit = (state == WAIT) && !bus.alu_rdy && (wait_cnt == TW'(TIMEOUT - 1));
    assign bus.err     = err_q;
    assign unused_ok   = ^flags[1:0];

    // Count WAIT cycles and latch a timeout as a sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + TW'(1) : '0;
            if (timeout_hit) err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign bus.err     = 1'b0;
    assign unused_ok   = (^flags[1:0]) ^ (TIMEOUT > 0);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    // Next state and memory/ALU strobes
    always_comb begin
        state_nxt       = state;
        bus.we          = 1'b0;
        bus.alu_bgn     = 1'b0;
        bus.ram_address = RAM_SIZE'(imm);
        bus.ram_out     = regs[rsel];
        case (state)
            FETCH: state_nxt = DECODE;
            DECODE: begin
                state_nxt = FETCH;
                if (is_alu) begin
                    bus.alu_bgn = 1'b1;
                    state_nxt   = WAIT;
                end else begin
                    case (op)
                        OP_LDR:  state_nxt = MEM;
                        OP_STR:  bus.we = 1'b1;
                        OP_PUSH: begin
                            bus.ram_address = sp;
                            bus.we          = 1'b1;
                        end
                        OP_POP: begin
                            bus.ram_address = sp_inc;
                            state_nxt       = MEM;
                        end
                        OP_HLT:  state_nxt = HALT;
                        default: state_nxt = FETCH;
                    endcase
                end
            end
            MEM: begin
                if (op == OP_POP) bus.ram_address = sp_inc;
                state_nxt = FETCH;
            end
            WAIT:    if (bus.alu_rdy || timeout_hit) state_nxt = FETCH;
            HALT:    state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
    end

    // Latch the instruction word while it is valid on the ROM bus
    always_ff @(posedge clk) begin
        if (state == DECODE) ir <= bus.instr;
    end

    // Architectural state: register file, flags, PC and SP
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= '0;
            sp    <= '1;
            flags <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            case (state)
                DECODE: begin
                    case (op)
                        OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_LDR, OP_POP, OP_HLT: ;
                        OP_BRZ:  pc <= flags[3] ? target : pc_inc;
                        OP_BRN:  pc <= flags[2] ? target : pc_inc;
                        OP_JMP:  pc <= target;
                        OP_MOVI: begin
                            regs[rsel] <= DATA_W'(imm);
                            pc         <= pc_inc;
                        end
                        OP_PUSH: begin
                            sp <= sp_dec;
                            pc <= pc_inc;
                        end
                        default: pc <= pc_inc;
                    endcase
                end
                MEM: begin
                    regs[rsel] <= bus.ram_in;
                    pc         <= pc_inc;
                    if (op == OP_POP) sp <= sp_inc;
                end
                WAIT: begin
                    if (bus.alu_rdy) begin
                        regs[rsel] <= bus.alu_res;
                        flags      <= bus.alu_flags;
                        pc         <= pc_inc;
                    end else if (timeout_hit) begin
                        pc <= pc_inc;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_control_unit.sv
// Bench for seq_control_unit: ROM, RAM and ALU models around the DUT, programs
// per scenario, and a scoreboard of expected RAM writes checked as they occur.
module tb_seq_control_unit;
    localparam int DATA_W   = 16;
    localparam int ROM_SIZE = 16;
    localparam int RAM_SIZE = 16;
    localparam int TIMEOUT  = 4;

    localparam logic [5:0] NOP = 6'd0, ADD = 6'd1, SUB = 6'd2, SHL = 6'd3;
    localparam logic [5:0] BRZ = 6'd5, BRN = 6'd6, JMP = 6'd7, LDR = 6'd8;
    localparam logic [5:0] STR = 6'd9, MOVI = 6'd10, PUSH = 6'd11, POP = 6'd12, HLT = 6'd13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_control_unit_if #(.DATA_W(DATA_W), .ROM_SIZE(ROM_SIZE), .RAM_SIZE(RAM_SIZE)) bus();

    seq_control_unit #(.DATA_W(DATA_W), .ROM_SIZE(ROM_SIZE), .RAM_SIZE(RAM_SIZE), .TIMEOUT(TIMEOUT))
        dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    typedef struct packed { logic [15:0] addr; logic [15:0] data; } wr_t;
    wr_t exp_wr[$];

    logic [15:0] rom [0:1023];
    logic [15:0] ram [0:65535];
    logic [15:0] instr_r  = 16'h0;
    logic [15:0] ram_in_r = 16'h0;

    // ROM and RAM: one-cycle synchronous read
    always @(posedge clk) begin
        instr_r  <= rom[bus.rom_address[9:0]];
        ram_in_r <= ram[bus.ram_address];
        if (bus.we) ram[bus.ram_address] = bus.ram_out;
    end
    assign bus.instr  = instr_r;
    assign bus.ram_in = ram_in_r;

    // ALU model: result at alu_bgn, alu_rdy alu_lat cycles later (0 = never)
    int          alu_lat   = 1;
    logic        force_en  = 1'b0;
    logic [3:0]  force_flg = 4'h0;
    logic        alu_busy  = 1'b0;
    logic        alu_rdy_r = 1'b0;
    int          alu_left  = 0;
    logic [15:0] alu_res_r = 16'h0;
    logic [3:0]  alu_flg_r = 4'h0;
    logic [15:0] cap_a = 16'h0, cap_b = 16'h0;
    logic [5:0]  cap_op = 6'h0;
    logic        stab_en = 1'b0;
    int          unstable_cnt = 0;
    int          bgn_cnt = 0;

    function automatic logic [15:0] alu_calc(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            6'd1:    return a + b;
            6'd2:    return a - b;
            6'd3:    return a << b[3:0];
            6'd4:    return a >> b[3:0];
            default: return 16'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (alu_rdy_r) begin
            alu_rdy_r <= 1'b0;
            alu_busy  <= 1'b0;
        end else if (bus.alu_bgn) begin
            cap_a     <= bus.alu_a;
            cap_b     <= bus.alu_b;
            cap_op    <= bus.alu_op;
            alu_res_r <= alu_calc(bus.alu_op, bus.alu_a, bus.alu_b);
            alu_flg_r <= force_en ? force_flg :
                         {alu_calc(bus.alu_op, bus.alu_a, bus.alu_b) == 16'h0,
                          alu_calc(bus.alu_op, bus.alu_a, bus.alu_b) >= 16'h8000, 2'b00};
            alu_busy  <= 1'b1;
            alu_rdy_r <= (alu_lat == 1);
            alu_left  <= alu_lat - 1;
        end else if (alu_busy && alu_lat > 1) begin
            if (alu_left == 1) alu_rdy_r <= 1'b1;
            alu_left <= alu_left - 1;
        end
    end
    assign bus.alu_res   = alu_res_r;
    assign bus.alu_flags = alu_flg_r;
    assign bus.alu_rdy   = alu_rdy_r;

    // Monitors: RAM write scoreboard, alu_bgn count, operand stability in WAIT
    always @(negedge clk) begin
        if (!rst && bus.we) begin
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL ram_write unexpected: addr=%h data=%h", bus.ram_address, bus.ram_out);
            end else begin
                wr_t w;
                w = exp_wr.pop_front();
                if ({bus.ram_address, bus.ram_out} !== {w.addr, w.data}) begin
                    errors++;
                    $display("FAIL ram_write got addr=%h data=%h expected addr=%h data=%h",
                             bus.ram_address, bus.ram_out, w.addr, w.data);
                end
            end
        end
        if (!rst && bus.alu_bgn) bgn_cnt++;
        if (stab_en && alu_busy && {bus.alu_a, bus.alu_b, bus.alu_op} !== {cap_a, cap_b, cap_op})
            unstable_cnt++;
    end

    function automatic logic [15:0] enc(input logic [5:0] op, input logic [1:0] r, input logic [7:0] imm);
        return {op, r, imm};
    endfunction

    function automatic logic [15:0] encb(input logic [5:0] op, input logic [9:0] tgt);
        return {op, tgt};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) rom[i] = enc(HLT, 2'd0, 8'h00);
        for (int i = 0; i < 65536; i++) ram[i] = 16'h0;
        exp_wr.delete();
        bgn_cnt = 0;
        unstable_cnt = 0;
        force_en = 1'b0;
    endtask

    // Leaves the bench #1 after the reset edge: cycle 0, state FETCH
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_halt(input int max_cyc, output int cyc);
        cyc = 0;
        while (bus.halted !== 1'b1 && cyc < max_cyc) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        clear_mem();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (bus.rom_address !== 16'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0000", bus.rom_address); end
        checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", bus.we); end
        checks++; if (bus.alu_bgn !== 1'b0) begin errors++; $display("FAIL reset_alu_bgn got=%b exp=0", bus.alu_bgn); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    endtask

    task automatic test_alu();
        int cyc;
        logic [15:0] pc_h;
        clear_mem();
        rom[0] = enc(MOVI, 2'd0, 8'd5);
        rom[1] = enc(MOVI, 2'd1, 8'd3);
        rom[2] = enc(ADD,  2'd0, 8'd1);
        rom[3] = encb(BRZ, 10'h03F);
        rom[4] = enc(STR,  2'd0, 8'h20);
        rom[5] = enc(HLT,  2'd0, 8'h00);
        exp_wr.push_back({16'h0020, 16'd8});
        alu_lat = 2;
        stab_en = 1'b1;
        do_reset();
        wait_halt(100, cyc);
        stab_en = 1'b0;
        checks++; if (cyc !== 14) begin errors++; $display("FAIL alu_cycles got=%0d exp=14", cyc); end
        checks++; if (bus.rom_address !== 16'd5) begin errors++; $display("FAIL alu_final_pc got=%h exp=0005", bus.rom_address); end
        checks++; if (bgn_cnt !== 1) begin errors++; $display("FAIL alu_bgn_pulses got=%0d exp=1", bgn_cnt); end
        checks++; if ({cap_op, cap_a, cap_b} !== {6'd1, 16'd5, 16'd3}) begin errors++; $display("FAIL alu_operands got op=%0d a=%0d b=%0d exp op=1 a=5 b=3", cap_op, cap_a, cap_b); end
        checks++; if (unstable_cnt !== 0) begin errors++; $display("FAIL alu_operand_stability got=%0d exp=0", unstable_cnt); end
        checks++; if (exp_wr.size() !== 0) begin errors++; $display("FAIL alu_pending_writes got=%0d exp=0", exp_wr.size()); end
        pc_h = bus.rom_address;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (bus.rom_address !== pc_h || bus.halted !== 1'b1) begin errors++; $display("FAIL halt_frozen got pc=%h halted=%b exp pc=%h halted=1", bus.rom_address, bus.halted, pc_h); end
    endtask

    task automatic test_branch();
        int cyc;
        logic [5:0]  br_op [4]   = '{BRZ, BRZ, BRN, BRN};
        logic        f_en  [4]   = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0]  f_val [4]   = '{4'b0000, 4'b0000, 4'b0100, 4'b0000};
        logic        taken [4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            clear_mem();
            rom[0]    = enc(MOVI, 2'd0, 8'd7);
            rom[1]    = enc(SUB,  2'd0, 8'd0);
            rom[2]    = encb(br_op[k], 10'h020);
            rom[3]    = enc(STR,  2'd0, 8'h30);
            rom[4]    = enc(HLT,  2'd0, 8'h00);
            rom[32]   = enc(MOVI, 2'd3, 8'hAA);
            rom[33]   = enc(STR,  2'd3, 8'h31);
            rom[34]   = enc(HLT,  2'd0, 8'h00);
            force_en  = f_en[k];
            force_flg = f_val[k];
            alu_lat   = 1;
            if (taken[k]) exp_wr.push_back({16'h0031, 16'h00AA});
            else          exp_wr.push_back({16'h0030, 16'h0000});
            do_reset();
            wait_halt(100, cyc);
            checks++; if (cyc !== (taken[k] ? 13 : 11)) begin errors++; $display("FAIL branch%0d_cycles got=%0d exp=%0d", k, cyc, taken[k] ? 13 : 11); end
            checks++; if (bus.rom_address !== (taken[k] ? 16'h0022 : 16'h0004)) begin errors++; $display("FAIL branch%0d_pc got=%h exp=%h", k, bus.rom_address, taken[k] ? 16'h0022 : 16'h0004); end
            checks++; if (exp_wr.size() !== 0) begin errors++; $display("FAIL branch%0d_pending_writes got=%0d exp=0", k, exp_wr.size()); end
        end
        force_en = 1'b0;
    endtask

    task automatic test_mem();
        int cyc;
        clear_mem();
        rom[0] = enc(MOVI, 2'd2, 8'hBE);
        rom[1] = enc(MOVI, 2'd1, 8'd8);
        rom[2] = enc(SHL,  2'd2, 8'd1);
        rom[3] = enc(MOVI, 2'd0, 8'hEF);
        rom[4] = enc(ADD,  2'd2, 8'd0);
        rom[5] = enc(STR,  2'd2, 8'h10);
        rom[6] = enc(LDR,  2'd3, 8'h10);
        rom[7] = enc(STR,  2'd3, 8'h11);
        rom[8] = enc(HLT,  2'd0, 8'h00);
        exp_wr.push_back({16'h0010, 16'hBEEF});
        exp_wr.push_back({16'h0011, 16'hBEEF});
        alu_lat = 1;
        stab_en = 1'b1;
        do_reset();
        wait_halt(100, cyc);
        stab_en = 1'b0;
        checks++; if (cyc !== 21) begin errors++; $display("FAIL mem_cycles got=%0d exp=21", cyc); end
        checks++; if (bus.rom_address !== 16'd8) begin errors++; $display("FAIL mem_pc got=%h exp=0008", bus.rom_address); end
        checks++; if (exp_wr.size() !== 0) begin errors++; $display("FAIL mem_pending_writes got=%0d exp=0", exp_wr.size()); end
    endtask

    task automatic test_stack();
        int cyc;
        clear_mem();
        rom[0]  = enc(MOVI, 2'd1, 8'h5A);
        rom[1]  = enc(PUSH, 2'd1, 8'h00);
        rom[2]  = enc(POP,  2'd2, 8'h00);
        rom[3]  = encb(JMP, 10'h008);
        rom[4]  = enc(STR,  2'd1, 8'h77);
        rom[8]  = enc(PUSH, 2'd2, 8'h00);
        rom[9]  = enc(STR,  2'd2, 8'h40);
        rom[10] = enc(HLT,  2'd0, 8'h00);
        exp_wr.push_back({16'hFFFF, 16'h005A});
        exp_wr.push_back({16'hFFFF, 16'h005A});
        exp_wr.push_back({16'h0040, 16'h005A});
        do_reset();
        wait_halt(100, cyc);
        checks++; if (cyc !== 15) begin errors++; $display("FAIL stack_cycles got=%0d exp=15", cyc); end
        checks++; if (bus.rom_address !== 16'd10) begin errors++; $display("FAIL stack_pc got=%h exp=000a", bus.rom_address); end
        checks++; if (exp_wr.size() !== 0) begin errors++; $display("FAIL stack_pending_writes got=%0d exp=0", exp_wr.size()); end

        // POP straight out of reset wraps SP to 0
        clear_mem();
        ram[0] = 16'h1234;
        rom[0] = enc(POP,  2'd0, 8'h00);
        rom[1] = enc(PUSH, 2'd0, 8'h00);
        rom[2] = enc(PUSH, 2'd0, 8'h00);
        rom[3] = enc(HLT,  2'd0, 8'h00);
        exp_wr.push_back({16'h0000, 16'h1234});
        exp_wr.push_back({16'hFFFF, 16'h1234});
        do_reset();
        wait_halt(100, cyc);
        checks++; if (cyc !== 9) begin errors++; $display("FAIL popwrap_cycles got=%0d exp=9", cyc); end
        checks++; if (exp_wr.size() !== 0) begin errors++; $display("FAIL popwrap_pending_writes got=%0d exp=0", exp_wr.size()); end
    endtask

    task automatic test_reset_in_wait();
        int cyc;
        int n;
        clear_mem();
        rom[0] = enc(MOVI, 2'd0, 8'd1);
        rom[1] = enc(MOVI, 2'd1, 8'd2);
        rom[2] = enc(ADD,  2'd0, 8'd1);
        rom[3] = enc(HLT,  2'd0, 8'h00);
        alu_lat = 4;
        do_reset();
        n = 0;
        while (bus.alu_bgn !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (n >= 20) begin errors++; $display("FAIL rstwait_bgn_seen got=0 exp=1"); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        // reset lands in the second WAIT cycle; the result arrives afterwards
        rst = 1'b1;
        rom[0] = enc(STR, 2'd0, 8'h50);
        rom[1] = enc(HLT, 2'd0, 8'h00);
        exp_wr.push_back({16'h0050, 16'h0000});
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (bus.rom_address !== 16'h0 || bus.halted !== 1'b0) begin errors++; $display("FAIL rstwait_state got pc=%h halted=%b exp pc=0000 halted=0", bus.rom_address, bus.halted); end
        wait_halt(100, cyc);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL rstwait_cycles got=%0d exp=4", cyc); end
        checks++; if (bus.rom_address !== 16'd1) begin errors++; $display("FAIL rstwait_pc got=%h exp=0001", bus.rom_address); end
        checks++; if (exp_wr.size() !== 0) begin errors++; $display("FAIL rstwait_pending_writes got=%0d exp=0", exp_wr.size()); end
    endtask

    task automatic load_timeout_prog();
        clear_mem();
        rom[0] = enc(MOVI, 2'd0, 8'd5);
        rom[1] = enc(MOVI, 2'd1, 8'd3);
        rom[2] = enc(ADD,  2'd0, 8'd1);
        rom[3] = enc(STR,  2'd0, 8'h60);
        rom[4] = enc(HLT,  2'd0, 8'h00);
    endtask

`ifdef CU_ALU_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        logic [15:0] pc_h;
        // alu_rdy in the last allowed WAIT cycle completes normally
        load_timeout_prog();
        exp_wr.push_back({16'h0060, 16'd8});
        alu_lat = 4;
        do_reset();
        wait_halt(100, cyc);
        checks++; if (cyc !== 14) begin errors++; $display("FAIL race_cycles got=%0d exp=14", cyc); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL race_err got=%b exp=0", bus.err); end
        checks++; if (exp_wr.size() !== 0) begin errors++; $display("FAIL race_pending_writes got=%0d exp=0", exp_wr.size()); end
        // no alu_rdy at all: abandon after TIMEOUT cycles, R0 untouched
        load_timeout_prog();
        exp_wr.push_back({16'h0060, 16'd5});
        alu_lat = 0;
        do_reset();
        wait_halt(100, cyc);
        checks++; if (cyc !== 14) begin errors++; $display("FAIL timeout_cycles got=%0d exp=14", cyc); end
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL timeout_err got=%b exp=1", bus.err); end
        checks++; if (exp_wr.size() !== 0) begin errors++; $display("FAIL timeout_pending_writes got=%0d exp=0", exp_wr.size()); end
        pc_h = bus.rom_address;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (bus.rom_address !== 16'd4 || pc_h !== 16'd4 || bus.halted !== 1'b1) begin errors++; $display("FAIL timeout_halt got pc=%h halted=%b exp pc=0004 halted=1", bus.rom_address, bus.halted); end
    endtask
`else
    task automatic test_wait_forever();
        load_timeout_prog();
        alu_lat = 0;
        do_reset();
        repeat (40) @(posedge clk);
        #1;
        checks++; if (bus.rom_address !== 16'd2) begin errors++; $display("FAIL waitforever_pc got=%h exp=0002", bus.rom_address); end
        checks++; if (bus.halted !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL waitforever_status got halted=%b err=%b exp halted=0 err=0", bus.halted, bus.err); end
        checks++; if (bgn_cnt !== 1) begin errors++; $display("FAIL waitforever_bgn_pulses got=%0d exp=1", bgn_cnt); end
        checks++; if (exp_wr.size() !== 0) begin errors++; $display("FAIL waitforever_pending_writes got=%0d exp=0", exp_wr.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_mem();
        test_stack();
        test_reset_in_wait();
`ifdef CU_ALU_TIMEOUT_EN
        test_timeout();
`else
        test_wait_forever();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired: errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
